// File: rtl/stage_id_ex_pipe_pkg.sv
// Shared CPU definitions for the ID/EX pipeline register: ALU op encoding and
// register-address width derivation (kept identical to the stall unit).
package stage_id_ex_pipe_pkg;

    localparam int ALU_OP_W = 5;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_AND  = 5'd2,
        ALU_OR   = 5'd3,
        ALU_XOR  = 5'd4,
        ALU_SLL  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_SLT  = 5'd8,
        ALU_SLTU = 5'd9,
        ALU_MADD = 5'd10
    } alu_op_e;

    function automatic int reg_addr_w(input int reg_num);
        return (reg_num > 1) ? $clog2(reg_num) : 1;
    endfunction

endpackage

// File: rtl/stage_id_ex_pipe_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; async active-high reset.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/stage_id_ex_pipe.sv
// ID->EX pipeline register with flush/hold/bubble handling and a saturating
// count of hazard bubbles inserted while ID held a real instruction.
module stage_id_ex_pipe
    import stage_id_ex_pipe_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int REG_NUM    = 32,
    localparam int RW        = reg_addr_w(REG_NUM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [ADDR_WIDTH-1:0] id_pc,
    input  logic [DATA_WIDTH-1:0] id_rs1_data,
    input  logic [DATA_WIDTH-1:0] id_rs2_data,
    input  logic [DATA_WIDTH-1:0] id_rs3_data,
    input  logic [DATA_WIDTH-1:0] id_imm,
    input  logic [RW-1:0]         id_rd_addr,
    input  logic                  id_rd_we,
    input  logic                  id_is_load,
    input  logic                  id_is_store,
    input  logic [ALU_OP_W-1:0]   id_alu_op,
    input  logic                  stall,
    input  logic                  ex_stall,
    input  logic                  flush,
    output logic                  id_ready,
    output logic                  ex_valid,
    output logic [ADDR_WIDTH-1:0] ex_pc,
    output logic [DATA_WIDTH-1:0] ex_rs1_data,
    output logic [DATA_WIDTH-1:0] ex_rs2_data,
    output logic [DATA_WIDTH-1:0] ex_rs3_data,
    output logic [DATA_WIDTH-1:0] ex_imm,
    output logic [RW-1:0]         ex_rd_addr,
    output logic                  ex_rd_we,
    output logic                  ex_is_load,
    output logic                  ex_is_store,
    output logic [ALU_OP_W-1:0]   ex_alu_op,
    output logic [31:0]           bubble_count
);

    logic                  valid_q, valid_d;
    logic                  rd_we_q, rd_we_d;
    logic                  is_load_q, is_load_d;
    logic                  is_store_q, is_store_d;
    logic [RW-1:0]         rd_addr_q, rd_addr_d;
    logic [ALU_OP_W-1:0]   alu_op_q, alu_op_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] rs1_q, rs1_d;
    logic [DATA_WIDTH-1:0] rs2_q, rs2_d;
    logic [DATA_WIDTH-1:0] rs3_q, rs3_d;
    logic [DATA_WIDTH-1:0] imm_q, imm_d;
    logic                  bubble_inc;

    assign id_ready   = !(stall | ex_stall) | flush;
    assign bubble_inc = !flush && !ex_stall && stall && id_valid;

    // Priority: flush > ex_stall > stall (bubble) > load
    always_comb begin
        valid_d    = valid_q;
        rd_we_d    = rd_we_q;
        is_load_d  = is_load_q;
        is_store_d = is_store_q;
        rd_addr_d  = rd_addr_q;
        alu_op_d   = alu_op_q;
        pc_d       = pc_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rs3_d      = rs3_q;
        imm_d      = imm_q;
        if (flush || (!ex_stall && stall)) begin
            valid_d    = 1'b0;
            rd_we_d    = 1'b0;
            is_load_d  = 1'b0;
            is_store_d = 1'b0;
        end else if (!ex_stall) begin
            valid_d    = id_valid;
            rd_we_d    = id_rd_we & id_valid & (id_rd_addr != '0);
            is_load_d  = id_is_load & id_valid;
            is_store_d = id_is_store & id_valid;
            rd_addr_d  = id_rd_addr;
            alu_op_d   = id_alu_op;
            pc_d       = id_pc;
            rs1_d      = id_rs1_data;
            rs2_d      = id_rs2_data;
            rs3_d      = id_rs3_data;
            imm_d      = id_imm;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            rd_we_q    <= 1'b0;
            is_load_q  <= 1'b0;
            is_store_q <= 1'b0;
            rd_addr_q  <= '0;
            alu_op_q   <= '0;
            pc_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rs3_q      <= '0;
            imm_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            rd_we_q    <= rd_we_d;
            is_load_q  <= is_load_d;
            is_store_q <= is_store_d;
            rd_addr_q  <= rd_addr_d;
            alu_op_q   <= alu_op_d;
            pc_q       <= pc_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rs3_q      <= rs3_d;
            imm_q      <= imm_d;
        end
    end

    sat_counter #(.WIDTH(32)) u_bubble_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc     (bubble_inc),
        .count_o (bubble_count)
    );

    assign ex_valid    = valid_q;
    assign ex_rd_we    = rd_we_q;
    assign ex_is_load  = is_load_q;
    assign ex_is_store = is_store_q;
    assign ex_rd_addr  = rd_addr_q;
    assign ex_alu_op   = alu_op_q;
    assign ex_pc       = pc_q;
    assign ex_rs1_data = rs1_q;
    assign ex_rs2_data = rs2_q;
    assign ex_rs3_data = rs3_q;
    assign ex_imm      = imm_q;

endmodule

// File: tb/tb_stage_id_ex_pipe.sv
// Directed bench for stage_id_ex_pipe: hazard bubble, EX hold, flush priority,
// x0 write suppression, counter saturation and asynchronous reset.
module tb_stage_id_ex_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [63:0] id_pc, id_rs1_data, id_rs2_data, id_rs3_data, id_imm;
    logic [4:0]  id_rd_addr;
    logic        id_rd_we, id_is_load, id_is_store;
    logic [4:0]  id_alu_op;
    logic        stall, ex_stall, flush;
    logic        id_ready, ex_valid;
    logic [63:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_rs3_data, ex_imm;
    logic [4:0]  ex_rd_addr;
    logic        ex_rd_we, ex_is_load, ex_is_store;
    logic [4:0]  ex_alu_op;
    logic [31:0] bubble_count;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    stage_id_ex_pipe dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_rs3_data(id_rs3_data), .id_imm(id_imm), .id_rd_addr(id_rd_addr),
        .id_rd_we(id_rd_we), .id_is_load(id_is_load), .id_is_store(id_is_store),
        .id_alu_op(id_alu_op), .stall(stall), .ex_stall(ex_stall), .flush(flush),
        .id_ready(id_ready), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_rs3_data(ex_rs3_data), .ex_imm(ex_imm), .ex_rd_addr(ex_rd_addr),
        .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
        .ex_alu_op(ex_alu_op), .bubble_count(bubble_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] pc, input logic [63:0] rs1,
                         input logic [4:0] rd, input logic we, input logic ld,
                         input logic st, input logic [4:0] op);
        id_valid    = v;
        id_pc       = pc;
        id_rs1_data = rs1;
        id_rs2_data = rs1 + 64'h1;
        id_rs3_data = rs1 + 64'h2;
        id_imm      = pc + 64'h10;
        id_rd_addr  = rd;
        id_rd_we    = we;
        id_is_load  = ld;
        id_is_store = st;
        id_alu_op   = op;
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0; ex_stall = 1'b0; flush = 1'b0;
        drive(1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        #2;
        chk("reset_ex_valid", {63'b0, ex_valid}, 64'h0);
        chk("reset_ex_pc", ex_pc, 64'h0);
        chk("reset_bubble_count", {32'b0, bubble_count}, 64'h0);
        step();
        rst = 1'b0;

        // Load x5 from memory
        drive(1'b1, 64'h100, 64'h11, 5'd5, 1'b1, 1'b1, 1'b0, 5'd3);
        step();
        chk("load_ex_valid", {63'b0, ex_valid}, 64'h1);
        chk("load_ex_pc", ex_pc, 64'h100);
        chk("load_ex_rs1", ex_rs1_data, 64'h11);
        chk("load_ex_rs3", ex_rs3_data, 64'h13);
        chk("load_ex_imm", ex_imm, 64'h110);
        chk("load_ex_rd_addr", {59'b0, ex_rd_addr}, 64'h5);
        chk("load_ex_is_load", {63'b0, ex_is_load}, 64'h1);
        chk("load_ex_rd_we", {63'b0, ex_rd_we}, 64'h1);
        chk("load_ex_alu_op", {59'b0, ex_alu_op}, 64'h3);

        // Consumer of x5 stalls one cycle
        drive(1'b1, 64'h104, 64'h55, 5'd6, 1'b1, 1'b0, 1'b0, 5'd1);
        stall = 1'b1;
        #1;
        chk("hazard_id_ready", {63'b0, id_ready}, 64'h0);
        step();
        chk("bubble_ex_valid", {63'b0, ex_valid}, 64'h0);
        chk("bubble_ex_is_load", {63'b0, ex_is_load}, 64'h0);
        chk("bubble_ex_rd_we", {63'b0, ex_rd_we}, 64'h0);
        chk("bubble_pc_hold", ex_pc, 64'h100);
        chk("bubble_count_1", {32'b0, bubble_count}, 64'h1);
        stall = 1'b0;
        #1;
        chk("after_hazard_id_ready", {63'b0, id_ready}, 64'h1);
        step();
        chk("consumer_ex_valid", {63'b0, ex_valid}, 64'h1);
        chk("consumer_ex_pc", ex_pc, 64'h104);
        chk("consumer_ex_rs1", ex_rs1_data, 64'h55);
        chk("consumer_ex_rd_addr", {59'b0, ex_rd_addr}, 64'h6);

        // Write to x0 is suppressed
        drive(1'b1, 64'h108, 64'h77, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2);
        step();
        chk("x0_ex_rd_we", {63'b0, ex_rd_we}, 64'h0);
        chk("x0_ex_valid", {63'b0, ex_valid}, 64'h1);
        chk("x0_ex_is_store", {63'b0, ex_is_store}, 64'h1);

        // Invalid ID gates control
        drive(1'b0, 64'h10c, 64'h88, 5'd7, 1'b1, 1'b1, 1'b1, 5'd4);
        step();
        chk("inv_ex_valid", {63'b0, ex_valid}, 64'h0);
        chk("inv_ex_is_load", {63'b0, ex_is_load}, 64'h0);
        chk("inv_ex_is_store", {63'b0, ex_is_store}, 64'h0);
        chk("inv_ex_rd_we", {63'b0, ex_rd_we}, 64'h0);
        stall = 1'b1;
        step();
        chk("inv_stall_no_count", {32'b0, bubble_count}, 64'h1);
        stall = 1'b0;

        // EX hold for three cycles
        drive(1'b1, 64'h1000, 64'h99, 5'd9, 1'b1, 1'b0, 1'b0, 5'd0);
        step();
        chk("hold_load_pc", ex_pc, 64'h1000);
        drive(1'b1, 64'h2000, 64'haa, 5'd10, 1'b1, 1'b0, 1'b0, 5'd1);
        ex_stall = 1'b1;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_id_ready", {63'b0, id_ready}, 64'h0);
            step();
            chk("hold_ex_pc", ex_pc, 64'h1000);
            chk("hold_ex_valid", {63'b0, ex_valid}, 64'h1);
        end
        chk("hold_no_count", {32'b0, bubble_count}, 64'h1);

        // Flush beats both stalls
        flush = 1'b1;
        #1;
        chk("flush_id_ready", {63'b0, id_ready}, 64'h1);
        step();
        chk("flush_ex_valid", {63'b0, ex_valid}, 64'h0);
        chk("flush_ex_rd_we", {63'b0, ex_rd_we}, 64'h0);
        chk("flush_no_count", {32'b0, bubble_count}, 64'h1);
        flush = 1'b0; stall = 1'b0; ex_stall = 1'b0;

        // Async reset in the middle of a hold
        drive(1'b1, 64'h3000, 64'hbb, 5'd12, 1'b1, 1'b1, 1'b0, 5'd6);
        step();
        chk("prereset_ex_pc", ex_pc, 64'h3000);
        ex_stall = 1'b1;
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ex_valid", {63'b0, ex_valid}, 64'h0);
        chk("arst_ex_pc", ex_pc, 64'h0);
        chk("arst_ex_rs1", ex_rs1_data, 64'h0);
        chk("arst_ex_rd_addr", {59'b0, ex_rd_addr}, 64'h0);
        chk("arst_ex_alu_op", {59'b0, ex_alu_op}, 64'h0);
        chk("arst_ex_is_load", {63'b0, ex_is_load}, 64'h0);
        chk("arst_bubble_count", {32'b0, bubble_count}, 64'h0);
        step();
        rst = 1'b0;
        ex_stall = 1'b0;
        drive(1'b1, 64'h4000, 64'hcc, 5'd3, 1'b1, 1'b0, 1'b0, 5'd1);
        step();
        chk("post_reset_ex_pc", ex_pc, 64'h4000);

        // Counter saturation
        dut.u_bubble_cnt.count_q = 32'hFFFF_FFFE;
        stall = 1'b1;
        step();
        chk("sat_step1", {32'b0, bubble_count}, 64'hFFFF_FFFF);
        step();
        chk("sat_step2", {32'b0, bubble_count}, 64'hFFFF_FFFF);
        step();
        chk("sat_step3", {32'b0, bubble_count}, 64'hFFFF_FFFF);
        stall = 1'b0;
        flush = 1'b1;
        step();
        chk("flush_keeps_count", {32'b0, bubble_count}, 64'hFFFF_FFFF);
        flush = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
